// File: rtl/muldiv_seq_pkg.sv
// Shared execute-stage types: ALU opcode encoding, mul/div sequencer states
// and opcode classification helpers.
package muldiv_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_PASSB = 4'd11,
    ALU_MUL   = 4'd12,
    ALU_MULH  = 4'd13,
    ALU_DIV   = 4'd14,
    ALU_REM   = 4'd15
  } alu_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  function automatic logic is_muldiv(logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_divop(logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring divide step, selected by is_div.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN:0]   acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN:0]   acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          ge;

  // Multiply: {acc,lo} holds partial product / remaining multiplier bits.
  assign sum     = acc + {1'b0, (lo[0] ? opb : {XLEN{1'b0}})};
  // Divide: acc is the partial remainder, lo shifts dividend out and quotient in.
  assign shifted = {acc[XLEN-1:0], lo[XLEN-1]};
  assign ge      = (shifted >= {1'b0, opb});

  always_comb begin
    if (is_div) begin
      acc_nxt = ge ? (shifted - {1'b0, opb}) : shifted;
      lo_nxt  = {lo[XLEN-2:0], ge};
    end else begin
      acc_nxt = {1'b0, sum[XLEN:1]};
      lo_nxt  = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/MULH/DIV/REM unit beside the execute-stage ALU; one
// iteration per cycle on a shared datapath, result held until writeback.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]   acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  alu_e            op_q, op_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;

  logic            accept;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div0, ovf;
  logic [XLEN:0]   step_acc;
  logic [XLEN-1:0] step_lo;
  logic [XLEN-1:0] fin;

  assign req_ready  = (state_q == MD_IDLE);
  assign busy       = (state_q != MD_IDLE);
  assign resp_valid = (state_q == MD_DONE);
  assign resp_data  = data_q;
  assign resp_rd    = rd_q;

  assign accept = req_valid && req_ready && !flush;
  assign mag_a  = req_a[XLEN-1] ? -req_a : req_a;
  assign mag_b  = req_b[XLEN-1] ? -req_b : req_b;
  assign div0   = (req_b == '0);
  assign ovf    = (req_a == MOST_NEG) && (req_b == '1);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_divop(op_q)),
    .acc     (acc_q),
    .lo      (lo_q),
    .opb     (opb_q),
    .acc_nxt (step_acc),
    .lo_nxt  (step_lo)
  );

  // Sign correction applied to the final iteration's output. MULH high half
  // of the negated 2*XLEN product is ~hi, plus the carry when lo is zero.
  always_comb begin
    fin = '0;
    case (op_q)
      ALU_MUL:  fin = step_lo;
      ALU_MULH: fin = (sa_q ^ sb_q)
                      ? (~step_acc[XLEN-1:0]) + {{(XLEN-1){1'b0}}, (step_lo == '0)}
                      : step_acc[XLEN-1:0];
      ALU_DIV:  fin = (sa_q ^ sb_q) ? -step_lo : step_lo;
      ALU_REM:  fin = sa_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
      default:  fin = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rd_d    = rd_q;
    data_d  = data_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d  = alu_e'(req_op);
          rd_d  = req_rd;
          sa_d  = req_a[XLEN-1];
          sb_d  = req_b[XLEN-1];
          acc_d = '0;
          if (!is_muldiv(req_op)) begin
            data_d  = '0;
            state_d = MD_DONE;
          end else if (is_divop(req_op) && div0) begin
            data_d  = (req_op == ALU_DIV) ? '1 : req_a;
            state_d = MD_DONE;
          end else if (is_divop(req_op) && ovf) begin
            data_d  = (req_op == ALU_DIV) ? req_a : '0;
            state_d = MD_DONE;
          end else begin
            // MUL low half is sign-independent, so raw operands suffice.
            lo_d    = (req_op == ALU_MUL) ? req_a : mag_a;
            opb_d   = (req_op == ALU_MUL) ? req_b : mag_b;
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        if (cnt_q == '0) begin
          data_d  = fin;
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MD_DONE: begin
        if (resp_ready) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush) state_d = MD_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      op_q    <= ALU_ADD;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: expected results are queued at accept
// time from a reference model and popped when the response appears.
module tb_muldiv_seq;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    int          edges;
  } exp_t;
  exp_t exp_q[$];

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    longint      sp;
    case (op)
      4'd12: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      4'd13: begin sp = longint'($signed(a)) * longint'($signed(b)); p = sp; return p[63:32]; end
      4'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      4'd15: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit special(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    if (op < 4'd12) return 1'b1;
    if (op >= 4'd14 && (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one request for a single cycle; returns #1 after the accept edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit push);
    exp_t e;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (push) begin
      e.d = model(op, a, b);
      e.rd = rd;
      e.edges = special(op, a, b) ? 0 : XLEN;
      exp_q.push_back(e);
    end
  endtask

  // Counts clock edges after the accept edge until resp_valid, bounded.
  task automatic wait_resp(output int edges, output bit busy_ok);
    edges = 0;
    busy_ok = 1'b1;
    while (!resp_valid && edges < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
    total++; if (resp_rd !== 5'h0) begin bad++; $display("FAIL reset_resp_rd got=%h want=0", resp_rd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int edges; bit bok; exp_t e;
    send(4'd12, 32'd7, 32'd6, 5'd5, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul_busy_after_accept got=%b want=1", busy); end
    wait_resp(edges, bok);
    e = exp_q.pop_front();
    total++; if (edges !== e.edges) begin bad++; $display("FAIL mul_latency got=%0d want=%0d", edges, e.edges); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL mul_busy_held got=%b want=1", bok); end
    total++; if (resp_data !== e.d) begin bad++; $display("FAIL mul_data got=%h want=%h", resp_data, e.d); end
    total++; if (resp_rd !== e.rd) begin bad++; $display("FAIL mul_rd got=%h want=%h", resp_rd, e.rd); end
    release_resp();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mul_ready_after got=%b want=1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_arith();
    logic [3:0]  ops [15] = '{4'd13, 4'd13, 4'd13, 4'd14, 4'd15, 4'd14, 4'd15, 4'd14, 4'd15,
                              4'd14, 4'd15, 4'd0, 4'd12, 4'd14, 4'd15};
    logic [31:0] as  [15] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                              32'h8000_0000, 32'd3, 32'hFFFF_FFFF, 32'd7, 32'd7};
    logic [31:0] bs  [15] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd2,
                              32'hFFFF_FFFE, 32'hFFFF_FFFE};
    int edges; bit bok; exp_t e;
    for (int i = 0; i < 15; i++) begin
      send(ops[i], as[i], bs[i], 5'(i + 1), 1'b1);
      wait_resp(edges, bok);
      e = exp_q.pop_front();
      total++; if (edges !== e.edges) begin bad++; $display("FAIL arith%0d_latency got=%0d want=%0d", i, edges, e.edges); end
      total++; if (resp_data !== e.d) begin bad++; $display("FAIL arith%0d_data got=%h want=%h", i, resp_data, e.d); end
      total++; if (resp_rd !== e.rd) begin bad++; $display("FAIL arith%0d_rd got=%h want=%h", i, resp_rd, e.rd); end
      release_resp();
    end
  endtask

  task automatic test_backpressure();
    int edges; bit bok; exp_t e;
    send(4'd14, 32'd100, 32'd7, 5'd9, 1'b1);
    wait_resp(edges, bok);
    e = exp_q.pop_front();
    total++; if (edges !== e.edges) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", edges, e.edges); end
    // A request offered while DONE must not be taken.
    @(negedge clk);
    req_op = 4'd12; req_a = 32'd3; req_b = 32'd3; req_rd = 5'd30; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_valid got=%b want=1", c, resp_valid); end
      total++; if (resp_data !== e.d) begin bad++; $display("FAIL bp%0d_data got=%h want=%h", c, resp_data, e.d); end
      total++; if (resp_rd !== e.rd) begin bad++; $display("FAIL bp%0d_rd got=%h want=%h", c, resp_rd, e.rd); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_req_ready got=%b want=0", c, req_ready); end
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy got=%b want=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_no_extra_resp got=%b want=0", resp_valid); end
  endtask

  task automatic test_flush();
    int edges; bit bok; bit seen; exp_t e;
    send(4'd14, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", req_ready); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_resp got=%b want=0", seen); end
    // Flush coincident with a request blocks the accept.
    @(negedge clk);
    req_op = 4'd12; req_a = 32'd2; req_b = 32'd2; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_blocks_accept got=%b want=0", busy); end
    // Flush in DONE wins over resp_ready and drops the result.
    send(4'd14, 32'd5, 32'd0, 5'd7, 1'b0);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL flush_done_pre got=%b want=1", resp_valid); end
    @(negedge clk) begin flush = 1'b1; resp_ready = 1'b1; end
    @(posedge clk); #1 begin flush = 1'b0; resp_ready = 1'b0; end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_done_valid got=%b want=0", resp_valid); end
    send(4'd12, 32'd3, 32'd3, 5'd11, 1'b1);
    wait_resp(edges, bok);
    e = exp_q.pop_front();
    total++; if (edges !== e.edges) begin bad++; $display("FAIL flush_mul_latency got=%0d want=%0d", edges, e.edges); end
    total++; if (resp_data !== e.d) begin bad++; $display("FAIL flush_mul_data got=%h want=%h", resp_data, e.d); end
    release_resp();
  endtask

  task automatic test_reset_mid();
    int edges; bit bok; exp_t e;
    send(4'd14, 32'd100, 32'd7, 5'd4, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h want=0", resp_data); end
    total++; if (resp_rd !== 5'h0) begin bad++; $display("FAIL rstmid_rd got=%h want=0", resp_rd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    @(negedge clk) rst_n = 1'b1;
    send(4'd12, 32'd3, 32'd3, 5'd2, 1'b1);
    wait_resp(edges, bok);
    e = exp_q.pop_front();
    total++; if (edges !== e.edges) begin bad++; $display("FAIL rstmid_mul_latency got=%0d want=%0d", edges, e.edges); end
    total++; if (resp_data !== e.d) begin bad++; $display("FAIL rstmid_mul_data got=%h want=%h", resp_data, e.d); end
    total++; if (resp_rd !== e.rd) begin bad++; $display("FAIL rstmid_mul_rd got=%h want=%h", resp_rd, e.rd); end
    release_resp();
  endtask

  task automatic test_back_to_back();
    int edges; bit bok; exp_t e;
    logic [3:0] op; logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 4'(12 + $urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 4) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      send(op, a, b, 5'(20 + i), 1'b1);
      wait_resp(edges, bok);
      e = exp_q.pop_front();
      total++; if (edges !== e.edges) begin bad++; $display("FAIL b2b%0d_latency got=%0d want=%0d", i, edges, e.edges); end
      total++; if (resp_data !== e.d) begin bad++; $display("FAIL b2b%0d_data op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, resp_data, e.d); end
      total++; if (resp_rd !== e.rd) begin bad++; $display("FAIL b2b%0d_rd got=%h want=%h", i, resp_rd, e.rd); end
      release_resp();
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_arith();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
